// File: rtl/count_sequencer_if.sv
// Control bundle between the button/timer front end and the counter-chain sequencer.
// The sequencer sits on the slave side; the stimulus source sits on the master side.
interface count_sequencer_if #(
    parameter int unsigned TIMER_W = 8
) ();
    logic               ce_1ms;
    logic               btn_clr;
    logic               btn_load;
    logic               btn_step;
    logic               run;
    logic               up_in;
    logic [TIMER_W-1:0] period;
    logic               cnt_ce;
    logic               cnt_clr;
    logic               cnt_l;
    logic               cnt_up;
    logic               busy;
    logic               overrun;
    logic [15:0]        step_cnt;

    modport master (
        output ce_1ms, btn_clr, btn_load, btn_step, run, up_in, period,
        input  cnt_ce, cnt_clr, cnt_l, cnt_up, busy, overrun, step_cnt
    );

    modport slave (
        input  ce_1ms, btn_clr, btn_load, btn_step, run, up_in, period,
        output cnt_ce, cnt_clr, cnt_l, cnt_up, busy, overrun, step_cnt
    );
endinterface

// File: rtl/count_sequencer.sv
// Command sequencer for the cascaded counter chain: turns button edges and auto-step
// timer ticks into one-cycle clear/load/count strobes, spaced by a guard interval.
module count_sequencer #(
    parameter int unsigned GUARD_CYC = 2,
    parameter int unsigned TIMER_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    count_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGuard
    } state_e;

    // One-hot request selection: [0] clear, [1] load, [2] step
    localparam logic [2:0] SelClr  = 3'b001;
    localparam logic [2:0] SelLoad = 3'b010;
    localparam logic [2:0] SelStep = 3'b100;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2:0]         r_sel;
    logic [2:0]         w_sel_nxt;
    logic [3:0]         r_guard;
    logic [3:0]         w_guard_nxt;
    logic               r_cnt_up;
    logic               w_cnt_up_nxt;

    logic               r_btn_clr_d1;
    logic               r_btn_load_d1;
    logic               r_btn_step_d1;
    logic               w_rise_clr;
    logic               w_rise_load;
    logic               w_rise_step;

    logic               r_p_clr;
    logic               r_p_load;
    logic               r_p_step;
    logic               w_p_clr_nxt;
    logic               w_p_load_nxt;
    logic               w_p_step_nxt;

    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [TIMER_W-1:0] w_period_eff;
    logic [TIMER_W:0]   w_timer_inc;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic [15:0]        r_step_cnt;
    logic [15:0]        w_step_cnt_nxt;

    logic               w_svc_clr;
    logic               w_svc_load;
    logic               w_svc_step;

    assign w_rise_clr  = bus.btn_clr  & ~r_btn_clr_d1;
    assign w_rise_load = bus.btn_load & ~r_btn_load_d1;
    assign w_rise_step = bus.btn_step & ~r_btn_step_d1;

    // A period of 0 behaves as 1 ms
    assign w_period_eff = (bus.period == '0) ? TIMER_W'(1) : bus.period;
    assign w_timer_inc  = {1'b0, r_timer} + {{TIMER_W{1'b0}}, 1'b1};

    // Button history; resets high so a button held through reset is not an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_clr_d1  <= 1'b1;
            r_btn_load_d1 <= 1'b1;
            r_btn_step_d1 <= 1'b1;
        end else begin
            r_btn_clr_d1  <= bus.btn_clr;
            r_btn_load_d1 <= bus.btn_load;
            r_btn_step_d1 <= bus.btn_step;
        end
    end

    // FSM state, selected request, guard counter and latched direction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_sel    <= '0;
            r_guard  <= '0;
            r_cnt_up <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_guard  <= w_guard_nxt;
            r_cnt_up <= w_cnt_up_nxt;
        end
    end

    // Next-state decode; strobes are high only in the ISSUE cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_guard_nxt  = r_guard;
        w_cnt_up_nxt = r_cnt_up;
        w_svc_clr    = 1'b0;
        w_svc_load   = 1'b0;
        w_svc_step   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_p_clr || r_p_load || r_p_step) begin
                    w_state_nxt  = StIssue;
                    w_cnt_up_nxt = bus.up_in;
                    if (r_p_clr) begin
                        w_sel_nxt = SelClr;
                    end else if (r_p_load) begin
                        w_sel_nxt = SelLoad;
                    end else begin
                        w_sel_nxt = SelStep;
                    end
                end
            end
            StIssue: begin
                w_svc_clr   = r_sel[0];
                w_svc_load  = r_sel[1];
                w_svc_step  = r_sel[2];
                w_guard_nxt = '0;
                w_state_nxt = (GUARD_CYC > 0) ? StGuard : StIdle;
            end
            StGuard: begin
                if (r_guard == 4'(GUARD_CYC - 1)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_guard_nxt = r_guard + 4'd1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Pending flags, auto timer, overrun and step counter
    always_comb begin
        w_p_clr_nxt    = r_p_clr;
        w_p_load_nxt   = r_p_load;
        w_p_step_nxt   = r_p_step;
        w_timer_nxt    = r_timer;
        w_overrun_nxt  = r_overrun;
        w_step_cnt_nxt = r_step_cnt;
        if (w_svc_clr) begin
            w_p_clr_nxt    = 1'b0;
            w_p_load_nxt   = 1'b0;
            w_p_step_nxt   = 1'b0;
            w_overrun_nxt  = 1'b0;
            w_step_cnt_nxt = '0;
            w_timer_nxt    = '0;
        end else begin
            if (w_svc_load) begin
                w_p_load_nxt = 1'b0;
            end
            if (w_svc_step) begin
                w_p_step_nxt   = 1'b0;
                w_step_cnt_nxt = r_step_cnt + 16'd1;
            end
            if (!bus.run) begin
                w_timer_nxt = '0;
            end else if (bus.ce_1ms) begin
                if (w_timer_inc >= {1'b0, w_period_eff}) begin
                    w_timer_nxt = '0;
                    // A step still waiting (and not leaving this cycle) absorbs the tick
                    if (r_p_step && !w_svc_step) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_p_step_nxt = 1'b1;
                    end
                end else begin
                    w_timer_nxt = w_timer_inc[TIMER_W-1:0];
                end
            end
        end
        // Fresh edges win over a service of the same flag in this cycle
        if (w_rise_clr) begin
            w_p_clr_nxt = 1'b1;
        end
        if (w_rise_load) begin
            w_p_load_nxt = 1'b1;
        end
        if (w_rise_step) begin
            w_p_step_nxt = 1'b1;
        end
    end

    // Request flag and bookkeeping registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p_clr    <= 1'b0;
            r_p_load   <= 1'b0;
            r_p_step   <= 1'b0;
            r_timer    <= '0;
            r_overrun  <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_p_clr    <= w_p_clr_nxt;
            r_p_load   <= w_p_load_nxt;
            r_p_step   <= w_p_step_nxt;
            r_timer    <= w_timer_nxt;
            r_overrun  <= w_overrun_nxt;
            r_step_cnt <= w_step_cnt_nxt;
        end
    end

    assign bus.cnt_clr  = w_svc_clr;
    assign bus.cnt_l    = w_svc_load;
    assign bus.cnt_ce   = w_svc_step;
    assign bus.cnt_up   = r_cnt_up;
    assign bus.busy     = (r_state != StIdle);
    assign bus.overrun  = r_overrun;
    assign bus.step_cnt = r_step_cnt;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: dut0 uses a 2-cycle guard, dut1 a 15-cycle guard.
module tb_count_sequencer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    count_sequencer_if #(.TIMER_W(8)) if0 ();
    count_sequencer_if #(.TIMER_W(8)) if1 ();

    count_sequencer #(.GUARD_CYC(2), .TIMER_W(8)) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0)
    );

    count_sequencer #(.GUARD_CYC(15), .TIMER_W(8)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if0.btn_step = 1'b1;
        clk_n(2);
        n_vec++;
        if (if0.cnt_ce !== 1'b0 || if0.busy !== 1'b0 || if0.step_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset0: ce=%b busy=%b cnt=%0d, need 0/0/0",
                     if0.cnt_ce, if0.busy, if0.step_cnt);
        end
        n_vec++;
        if (if1.overrun !== 1'b0 || if1.cnt_up !== 1'b0 || if1.step_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset1: ovr=%b up=%b cnt=%0d, need 0/0/0",
                     if1.overrun, if1.cnt_up, if1.step_cnt);
        end
        rst_n = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                clk_n(1);
                if (if0.cnt_ce !== 1'b0 || if0.busy !== 1'b0) seen = 1'b1;
            end
            n_vec++;
            if (seen) begin
                n_err++;
                $display("FAIL held_btn: activity seen=1, need 0");
            end
        end
        if0.btn_step = 1'b0;
        clk_n(1);
        if0.btn_step = 1'b1;
        clk_n(1);
        n_vec++;
        if (if0.cnt_ce !== 1'b0) begin
            n_err++;
            $display("FAIL step_lat1: cnt_ce=%b, need 0", if0.cnt_ce);
        end
        clk_n(1);
        n_vec++;
        if (if0.cnt_ce !== 1'b1 || if0.cnt_up !== 1'b0) begin
            n_err++;
            $display("FAIL step_lat2: cnt_ce=%b up=%b, need 1/0", if0.cnt_ce, if0.cnt_up);
        end
        clk_n(1);
        n_vec++;
        if (if0.cnt_ce !== 1'b0 || if0.step_cnt !== 16'd1 || if0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL step_after: ce=%b cnt=%0d busy=%b, need 0/1/1",
                     if0.cnt_ce, if0.step_cnt, if0.busy);
        end
        if0.btn_step = 1'b0;
        clk_n(4);
    endtask

    task automatic test_simultaneous;
        if0.btn_clr  = 1'b1;
        if0.btn_load = 1'b1;
        if0.btn_step = 1'b1;
        clk_n(2);
        n_vec++;
        if (if0.cnt_clr !== 1'b1 || if0.cnt_l !== 1'b0 || if0.cnt_ce !== 1'b0 ||
            if0.step_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL simul_issue: clr=%b l=%b ce=%b cnt=%0d, need 1/0/0/1",
                     if0.cnt_clr, if0.cnt_l, if0.cnt_ce, if0.step_cnt);
        end
        clk_n(1);
        n_vec++;
        if (if0.step_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL simul_cnt: step_cnt=%0d, need 0", if0.step_cnt);
        end
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                clk_n(1);
                if (if0.cnt_l !== 1'b0 || if0.cnt_ce !== 1'b0) seen = 1'b1;
            end
            n_vec++;
            if (seen || if0.busy !== 1'b0) begin
                n_err++;
                $display("FAIL simul_flush: late strobe=%b busy=%b, need 0/0", seen, if0.busy);
            end
        end
        if0.btn_clr  = 1'b0;
        if0.btn_load = 1'b0;
        if0.btn_step = 1'b0;
        clk_n(2);
    endtask

    task automatic test_load_then_step;
        int gap = -1;
        if0.btn_load = 1'b1;
        clk_n(1);
        if0.btn_step = 1'b1;
        clk_n(1);
        n_vec++;
        if (if0.cnt_l !== 1'b1 || if0.cnt_ce !== 1'b0) begin
            n_err++;
            $display("FAIL load_issue: cnt_l=%b ce=%b, need 1/0", if0.cnt_l, if0.cnt_ce);
        end
        for (int i = 1; i <= 10 && gap < 0; i++) begin
            clk_n(1);
            if (if0.cnt_ce === 1'b1) gap = i;
        end
        n_vec++;
        if (gap !== 4) begin
            n_err++;
            $display("FAIL load_step_gap: gap=%0d cycles, need 4", gap);
        end
        clk_n(1);
        n_vec++;
        if (if0.step_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL load_step_cnt: step_cnt=%0d, need 1", if0.step_cnt);
        end
        if0.btn_load = 1'b0;
        if0.btn_step = 1'b0;
        clk_n(6);
    endtask

    // ce_1ms every 10 clocks; strobes must be exp_gap apart, four of them in the window
    task automatic auto_run(input logic [7:0] per, input int exp_gap);
        int last = -1;
        int n_ce = 0;
        if0.run    = 1'b0;
        if0.period = per;
        clk_n(2);
        if0.run = 1'b1;
        for (int c = 0; c < 4 * exp_gap; c++) begin
            if0.ce_1ms = (c % 10 == 0);
            clk_n(1);
            if (if0.cnt_ce === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (c - last !== exp_gap) begin
                        n_err++;
                        $display("FAIL auto_gap p=%0d: gap=%0d, need %0d", per, c - last, exp_gap);
                    end
                end
                last = c;
                n_ce++;
            end
        end
        if0.ce_1ms = 1'b0;
        if0.run    = 1'b0;
        n_vec++;
        if (n_ce !== 4) begin
            n_err++;
            $display("FAIL auto_count p=%0d: strobes=%0d, need 4", per, n_ce);
        end
    endtask

    task automatic test_auto;
        auto_run(8'd3, 30);
        auto_run(8'd0, 10);
        clk_n(4);
        n_vec++;
        if (if0.step_cnt !== 16'd9 || if0.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL auto_total: step_cnt=%0d ovr=%b, need 9/0", if0.step_cnt, if0.overrun);
        end
    endtask

    task automatic test_overrun;
        bit found = 1'b0;
        if1.period = 8'd1;
        if1.run    = 1'b1;
        if1.ce_1ms = 1'b1;
        clk_n(20);
        n_vec++;
        if (if1.overrun !== 1'b1 || if1.step_cnt === 16'd0) begin
            n_err++;
            $display("FAIL ovr_set: overrun=%b step_cnt=%0d, need 1 and nonzero",
                     if1.overrun, if1.step_cnt);
        end
        if1.run     = 1'b0;
        if1.ce_1ms  = 1'b0;
        if1.btn_clr = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            clk_n(1);
            if (if1.cnt_clr === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL ovr_clr_wait: cnt_clr seen=0 in 40 cycles, need 1");
        end
        clk_n(1);
        n_vec++;
        if (if1.overrun !== 1'b0 || if1.step_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL ovr_clr: overrun=%b step_cnt=%0d, need 0/0",
                     if1.overrun, if1.step_cnt);
        end
        if1.btn_clr = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                clk_n(1);
                if (if1.cnt_ce !== 1'b0) seen = 1'b1;
            end
            n_vec++;
            if (seen) begin
                n_err++;
                $display("FAIL ovr_flush: cnt_ce after clear=1, need 0");
            end
        end
    endtask

    task automatic test_direction;
        if0.up_in    = 1'b1;
        if0.btn_step = 1'b1;
        clk_n(2);
        n_vec++;
        if (if0.cnt_ce !== 1'b1 || if0.cnt_up !== 1'b1) begin
            n_err++;
            $display("FAIL dir_issue: ce=%b up=%b, need 1/1", if0.cnt_ce, if0.cnt_up);
        end
        clk_n(1);
        if0.up_in = 1'b0;
        clk_n(1);
        n_vec++;
        if (if0.cnt_up !== 1'b1 || if0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL dir_guard: up=%b busy=%b, need 1/1", if0.cnt_up, if0.busy);
        end
        clk_n(3);
        n_vec++;
        if (if0.cnt_up !== 1'b1 || if0.busy !== 1'b0) begin
            n_err++;
            $display("FAIL dir_idle: up=%b busy=%b, need 1/0", if0.cnt_up, if0.busy);
        end
        if0.btn_step = 1'b0;
        clk_n(1);
        if0.btn_step = 1'b1;
        clk_n(2);
        n_vec++;
        if (if0.cnt_ce !== 1'b1 || if0.cnt_up !== 1'b0) begin
            n_err++;
            $display("FAIL dir_next: ce=%b up=%b, need 1/0", if0.cnt_ce, if0.cnt_up);
        end
        if0.btn_step = 1'b0;
    endtask

    task automatic test_async_reset;
        clk_n(6);
        if0.btn_step = 1'b1;
        clk_n(2);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (if0.cnt_ce !== 1'b0 || if0.busy !== 1'b0 || if0.step_cnt !== 16'd0 ||
            if0.cnt_up !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: ce=%b busy=%b cnt=%0d up=%b, need 0/0/0/0",
                     if0.cnt_ce, if0.busy, if0.step_cnt, if0.cnt_up);
        end
        if0.btn_step = 1'b0;
        clk_n(1);
        rst_n = 1'b1;
        clk_n(2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if0.ce_1ms = 1'b0; if0.btn_clr = 1'b0; if0.btn_load = 1'b0; if0.btn_step = 1'b0;
        if0.run = 1'b0; if0.up_in = 1'b0; if0.period = 8'd0;
        if1.ce_1ms = 1'b0; if1.btn_clr = 1'b0; if1.btn_load = 1'b0; if1.btn_step = 1'b0;
        if1.run = 1'b0; if1.up_in = 1'b0; if1.period = 8'd0;
        test_reset();
        test_simultaneous();
        test_load_then_step();
        test_auto();
        test_overrun();
        test_direction();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
